// File: rtl/lsu_sram_slave.sv
// Word-array data memory behind the LSU's AR/R and AW/W/B channels; returns lane-shifted read data, applies lane-shifted sub-word stores.
// Latency: rvalid RD_LAT cycles after the AR handshake cycle; bvalid WR_LAT cycles after the commit cycle.
// Backpressure: one outstanding read and one outstanding write; R and B are held until rready/bready, readies stay low meanwhile.
module lsu_sram_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          RD_LAT      = 1,
    parameter int          WR_LAT      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic        bvalid,
    output logic [1:0]  bresp,
    input  logic        bready
);
    localparam int          AW     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN   = 32'(4 * DEPTH_WORDS);
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    localparam logic [1:0] W_IDLE   = 2'd0;
    localparam logic [1:0] W_COMMIT = 2'd1;
    localparam logic [1:0] W_WAIT   = 2'd2;
    localparam logic [1:0] W_RESP   = 2'd3;

    logic [31:0] mem [DEPTH_WORDS];

    function automatic logic in_range(input logic [31:0] a);
        return (a >= ADDR_BASE) && ((a - ADDR_BASE) < SPAN);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - ADDR_BASE) >> 2);
    endfunction

    // ---------------- read path ----------------
    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic       ar_fire;

    assign ar_fire = arvalid && arready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        if (in_range(araddr)) begin
                            rdata <= mem[word_idx(araddr)] >> {araddr[1:0], 3'b000};
                            rresp <= OKAY;
                        end else begin
                            rdata <= '0;
                            rresp <= SLVERR;
                        end
                        arready <= 1'b0;
                        // r_cnt counts the remaining wait cycles before rvalid
                        if (RD_LAT == 1) begin
                            rvalid  <= 1'b1;
                            r_state <= R_RESP;
                        end else begin
                            r_cnt   <= 4'(RD_LAT - 1);
                            r_state <= R_WAIT;
                        end
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_cnt   <= '0;
                        rvalid  <= 1'b1;
                        r_state <= R_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // ---------------- write path ----------------
    logic [1:0]  w_state;
    logic [3:0]  w_cnt;
    logic        aw_got, w_got;
    logic        aw_fire, w_fire;
    logic [31:0] aw_addr;
    logic [31:0] w_dat;
    logic [3:0]  w_strb;
    logic [7:0]  strb_sh;
    logic [31:0] lane_dat;
    logic        unused_strb_hi;

    assign aw_fire        = awvalid && awready;
    assign w_fire         = wvalid && wready;
    assign strb_sh        = {4'b0000, w_strb} << aw_addr[1:0];
    assign lane_dat       = w_dat << {aw_addr[1:0], 3'b000};
    assign unused_strb_hi = ^wstrb[7:4];

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state <= W_IDLE;
            w_cnt   <= '0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            aw_addr <= '0;
            w_dat   <= '0;
            w_strb  <= '0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_fire) begin
                        aw_addr <= awaddr;
                        aw_got  <= 1'b1;
                    end
                    if (w_fire) begin
                        w_dat  <= wdata;
                        w_strb <= wstrb[3:0];
                        w_got  <= 1'b1;
                    end
                    awready <= !(aw_got || aw_fire);
                    wready  <= !(w_got || w_fire);
                    if ((aw_got || aw_fire) && (w_got || w_fire))
                        w_state <= W_COMMIT;
                end
                W_COMMIT: begin
                    bresp  <= in_range(aw_addr) ? OKAY : SLVERR;
                    aw_got <= 1'b0;
                    w_got  <= 1'b0;
                    if (WR_LAT == 1) begin
                        bvalid  <= 1'b1;
                        w_state <= W_RESP;
                    end else begin
                        w_cnt   <= 4'(WR_LAT - 1);
                        w_state <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (w_cnt == 4'd1) begin
                        w_cnt   <= '0;
                        bvalid  <= 1'b1;
                        w_state <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt - 4'd1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Storage is never reset; lanes pushed past bit 31 by the offset are simply dropped.
    always_ff @(posedge clk) begin
        if (rst && (w_state == W_COMMIT) && in_range(aw_addr)) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_sh[i])
                    mem[word_idx(aw_addr)][8*i +: 8] <= lane_dat[8*i +: 8];
            end
        end
    end
endmodule
